// File: rtl/mau_pkg.sv
// Shared definitions for the memory access sequencer: state encoding, NOP word and defaults.
package mau_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] MAU_NOP = 32'h0000_0000;

    localparam int unsigned MAU_TIMEOUT_DEFAULT = 255;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts REQ cycles without ack; expired flags the last permitted wait cycle.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count_q;

    assign expired = (count_q == 16'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Converts controller memory strobes into a req/ack bus transaction, fills IR/MDR and stalls
// the controller until the access completes; sticky err on timeout or misaligned address.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = MAU_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic          iord,
    input  logic          ir_write,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] alu_out,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] ir,
    output logic [DW-1:0] mdr,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          err
);

    logic [1:0]    state_q, state_d;
    logic          bus_req_q;
    logic          we_q;
    logic          dst_ir_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] mdr_q;
    logic          err_q;

    logic          start;
    logic          ack_hit;
    logic          abort;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expired;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] load_data;

    assign addr_sel = iord ? alu_out : pc;

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        ack_hit     = 1'b0;
        abort       = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    start       = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (timer_expired) begin
                    abort   = 1'b1;
                    state_d = DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign load_data = ack_hit ? bus_rdata : DW'(MAU_NOP);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            dst_ir_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ir_q      <= '0;
            mdr_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            // Registered from next state so bus_req never glitches.
            bus_req_q <= (state_d == REQ);
            if (start) begin
                addr_q   <= {addr_sel[AW-1:2], 2'b00};
                we_q     <= mem_write;
                wdata_q  <= wdata;
                dst_ir_q <= ir_write & ~mem_write;
            end
            if ((start && misaligned(addr_sel[1:0])) || abort) begin
                err_q <= 1'b1;
            end
            if ((ack_hit || abort) && !we_q) begin
                if (dst_ir_q) begin
                    ir_q <= load_data;
                end else begin
                    mdr_q <= load_data;
                end
            end
        end
    end

    assign stall     = ((state_q == IDLE) && (mem_read || mem_write)) || (state_q == REQ);
    assign bus_req   = bus_req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected register/bus state queued per access and
// compared when bus_req falls.
module tb_mem_access_unit;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, iord, ir_write;
    logic [AW-1:0] pc, alu_out;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] ir, mdr;
    logic          bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          err;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] mdr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic prev_req = 1'b0;

    mem_access_unit #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .iord      (iord),
        .ir_write  (ir_write),
        .pc        (pc),
        .alu_out   (alu_out),
        .wdata     (wdata),
        .stall     (stall),
        .ir        (ir),
        .mdr       (mdr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Falling bus_req marks the end of an access (DONE, or IDLE after a reset).
    always @(negedge clk) begin
        if (prev_req && !bus_req) begin
            check_val("sb_pending", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_val("sb_ir", ir, mon_e.ir);
                check_val("sb_mdr", mdr, mon_e.mdr);
                check_val("sb_addr", bus_addr, mon_e.addr);
                check_val("sb_wdata", bus_wdata, mon_e.wdata);
                check_val("sb_we", 32'(bus_we), 32'(mon_e.we));
                check_val("sb_err", 32'(err), 32'(mon_e.err));
            end
        end
        prev_req <= bus_req;
    end

    task automatic access(input string tag, input logic rd, input logic wr, input logic io,
                          input logic irw, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdv, input int waits, input int exp_stall,
                          input int exp_req, input exp_t e);
        int stall_cnt = 0;
        int req_cnt   = 0;
        bit done      = 1'b0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        iord      = io;
        ir_write  = irw;
        if (io) alu_out = addr;
        else    pc = addr;
        wdata     = wd;
        bus_rdata = rdv;
        bus_ack   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (bus_req) req_cnt++;
            if (!stall) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            bus_ack = (waits >= 0) && (req_cnt == waits);
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check_val({tag, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        bus_ack   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_watchdog: observed time limit expected $finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0; ir_write = 1'b0;
        pc = '0; alu_out = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_req", 32'(bus_req), 32'd0);
        check_val("rst_we", 32'(bus_we), 32'd0);
        check_val("rst_addr", bus_addr, 32'h0);
        check_val("rst_wdata", bus_wdata, 32'h0);
        check_val("rst_ir", ir, 32'h0);
        check_val("rst_mdr", mdr, 32'h0);
        check_val("rst_err", 32'(err), 32'd0);

        // Fetch, zero wait states.
        access("fetch", 1, 0, 0, 1, 32'h0000_0040, 32'hAAAA_0000, 32'h8C22_0004, 0, 2, 1,
               '{ir: 32'h8C22_0004, mdr: 32'h0, addr: 32'h40, wdata: 32'hAAAA_0000,
                 we: 1'b0, err: 1'b0});
        // Load, three wait states.
        access("load", 1, 0, 1, 0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 5, 4,
               '{ir: 32'h8C22_0004, mdr: 32'hDEAD_BEEF, addr: 32'h100, wdata: 32'h0,
                 we: 1'b0, err: 1'b0});
        // Store with mem_read and ir_write also high: write wins, no register update.
        access("store", 1, 1, 1, 1, 32'h0000_0200, 32'h1234_5678, 32'hFFFF_FFFF, 0, 2, 1,
               '{ir: 32'h8C22_0004, mdr: 32'hDEAD_BEEF, addr: 32'h200, wdata: 32'h1234_5678,
                 we: 1'b1, err: 1'b0});
        // Timeout: no ack ever, NOP loaded into mdr.
        access("timeout", 1, 0, 1, 0, 32'h0000_0300, 32'h0, 32'h5555_5555, -1, 5, 4,
               '{ir: 32'h8C22_0004, mdr: 32'h0, addr: 32'h300, wdata: 32'h0,
                 we: 1'b0, err: 1'b1});
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("err_sticky", 32'(err), 32'd1);
        check_val("idle_req", 32'(bus_req), 32'd0);
        check_val("idle_addr_hold", bus_addr, 32'h300);

        pulse_reset();
        @(negedge clk);
        check_val("rst2_err", 32'(err), 32'd0);
        check_val("rst2_ir", ir, 32'h0);

        // Misaligned read: aligned address on the bus, err raised.
        access("misalign", 1, 0, 1, 0, 32'h0000_0203, 32'h0, 32'h0BAD_F00D, 1, 3, 2,
               '{ir: 32'h0, mdr: 32'h0BAD_F00D, addr: 32'h200, wdata: 32'h0,
                 we: 1'b0, err: 1'b1});

        // Reset in the second REQ cycle, then a late ack that must be ignored.
        sb_q.push_back('{ir: 32'h0, mdr: 32'h0, addr: 32'h0, wdata: 32'h0, we: 1'b0, err: 1'b0});
        @(posedge clk); #1;
        mem_read = 1'b1; ir_write = 1'b1; iord = 1'b0; pc = 32'h0000_0080;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; mem_read = 1'b0; ir_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        @(negedge clk);
        check_val("rstreq_req", 32'(bus_req), 32'd0);
        check_val("rstreq_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_val("lateack_ir", ir, 32'h0);
        check_val("lateack_mdr", mdr, 32'h0);
        check_val("lateack_req", 32'(bus_req), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory access sequencer sitting directly downstream of the multicycle controller's memory strobes (MemRead, MemWrite, IorD, IRWrite). Turns single-cycle strobes into a req/ack transaction on a single-ported memory bus, latches fetched words into the Instruction Register and Memory Data Register, and raises `stall` so the controller holds its state until the access completes. Also supplies a bus-timeout watchdog with a sticky error flag.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, max REQ cycles without ack before abort (1..2^16-1)

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `mem_read`  in  1  read strobe from controller
- `mem_write`  in  1  write strobe from controller; wins if both high
- `iord`  in  1  address select: 0 = `pc`, 1 = `alu_out`
- `ir_write`  in  1  read result goes to `ir` instead of `mdr`
- `pc`  in  AW  fetch address
- `alu_out`  in  AW  data address
- `wdata`  in  DW  store data (B register)
- `stall`  out  1  controller must hold state
- `ir`  out  DW  instruction register
- `mdr`  out  DW  memory data register
- `bus_req`  out  1  request, held until ack
- `bus_we`  out  1  write enable, stable while `bus_req`
- `bus_addr`  out  AW  word-aligned address, `{addr[AW-1:2],2'b00}`
- `bus_wdata`  out  DW  store data
- `bus_ack`  in  1  completion, one cycle
- `bus_rdata`  in  DW  read data, valid with `bus_ack`
- `err`  out  1  sticky: timeout or misaligned address

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: if `mem_read|mem_write`, register address (per `iord`), `we=mem_write`, `wdata`, and `dst_ir = ir_write & ~mem_write`; clear timer; -> REQ. Otherwise stay.
- REQ: `bus_req=1`. On `bus_ack`: read -> load `bus_rdata` into `ir` (dst_ir) or `mdr`; write -> no register update; -> DONE. Else timer+1; when timer reaches TIMEOUT-1 without ack: set `err`, load NOP 32'h0000_0000 into the read destination (reads only), -> DONE.
- DONE: one cycle, strobes ignored (they still belong to the controller's current state); -> IDLE.
- `stall = (IDLE & (mem_read|mem_write)) | REQ`. Low in DONE, so controller advances on the edge ending DONE.
- Misaligned address (`addr[1:0]!=0`) at capture: set `err`, access still performed at aligned address.
- `bus_ack` outside REQ ignored. `bus_addr/we/wdata` hold last captured values when idle.
- Reset values: state IDLE, `stall` 0 (combinational, follows strobes), `bus_req` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, `ir` 0, `mdr` 0, `err` 0, timer 0.
- `err` cleared only by `rst`.

## Timing
- Zero-wait memory (ack in first REQ cycle): strobe cycle 0 (IDLE, stall=1), REQ cycle 1 (stall=1, ack), `ir`/`mdr` valid cycle 2 (DONE, stall=0). Access = 3 cycles; N wait states add N.
- `bus_req` registered (state-decoded), never glitches; asserted exactly from first REQ cycle through ack cycle inclusive.
- Timeout: abort on edge after the TIMEOUT-th REQ cycle without ack; `err` visible in DONE.
- `rst` mid-REQ: next cycle IDLE, `bus_req` 0; late ack ignored.

## Structure
- Shared package `mau_pkg`: state enum (IDLE=2'd0, REQ=2'd1, DONE=2'd2), `MAU_NOP` constant, default TIMEOUT.
- One sub-module: `mem_wait_timer` (clear, enable, `expired` at TIMEOUT-1); rest in top.

## Test plan
- Fetch, zero-wait: pc=0x0000_0040, mem_read=ir_write=1, ack on first REQ with rdata=0x8C22_0004 -> stall high 2 cycles, ir=0x8C22_0004 in DONE, mdr unchanged.
- Load, 3 wait states: iord=1, alu_out=0x100, rdata=0xDEAD_BEEF -> bus_addr=0x100, bus_req 4 cycles, mdr=0xDEAD_BEEF, stall 5 cycles.
- Store with mem_read also high: alu_out=0x200, wdata=0x1234_5678 -> bus_we=1, bus_wdata=0x1234_5678, ir/mdr unchanged.
- Timeout: TIMEOUT=4, no ack -> bus_req 4 cycles, err=1, mdr=0, then IDLE; err persists until rst.
- Misaligned: alu_out=0x203 -> bus_addr=0x200, err=1 after capture.
- rst in 2nd REQ cycle, ack next cycle -> bus_req 0, ir/mdr=0, ack ignored, state IDLE.
